// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and receiver state encoding for the UART link
package uart_pkg;
   localparam int UART_CLKS_PER_BIT = 347;
   localparam int UART_BYTE_WIDTH = 8;
   typedef logic [2:0] state_t;
   localparam state_t IDLE  = 3'd0;
   localparam state_t START = 3'd1;
   localparam state_t DATA  = 3'd2;
   localparam state_t STOP  = 3'd3;
   localparam state_t BRK   = 3'd4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, m} <= {RST_VAL, RST_VAL};
      else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling 8N1 deframer with a one-entry byte buffer
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int BYTE_WIDTH = UART_BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  unload_uart,
   output logic [BYTE_WIDTH-1:0] dout,
   output logic                  byte_rdy,
   output logic                  frame_err,
   output logic                  overrun
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(BYTE_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BLAST = BW'(BYTE_WIDTH - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bidx;
   logic [BYTE_WIDTH-1:0] sh;
   logic rxs, tick, deliver;
   sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));
   assign tick = cnt == LAST;
   assign deliver = state == STOP && tick && rxs;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bidx <= '0;
         sh <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         cnt <= cnt + 1'b1;
         case (state)
            IDLE: if (!rxs) begin
               state <= START;
               cnt <= '0;
            end
            START: if (cnt == HALF) begin
               state <= rxs ? IDLE : DATA;
               cnt <= '0;
               bidx <= '0;
            end
            DATA: if (tick) begin
               sh <= {rxs, sh[BYTE_WIDTH-1:1]};
               cnt <= '0;
               bidx <= bidx + 1'b1;
               if (bidx == BLAST) state <= STOP;
            end
            STOP: if (tick) begin
               state <= rxs ? IDLE : BRK;
               frame_err <= !rxs;
            end
            BRK: if (rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   // an acknowledge in the stop-sample cycle frees the buffer for the new byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
         byte_rdy <= 1'b0;
         overrun <= 1'b0;
      end else if (deliver && (!byte_rdy || unload_uart)) begin
         dout <= sh;
         byte_rdy <= 1'b1;
      end else if (deliver) begin
         overrun <= 1'b1;
      end else if (unload_uart) begin
         byte_rdy <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: scenario tasks with a queue of expected bytes for uart_rx_byte
module tb_uart_rx_byte;
   localparam int CPB = 16;
   logic clk = 1'b0, rst = 1'b0, rx = 1'b1, unload_uart = 1'b0;
   logic [7:0] dout;
   logic byte_rdy, frame_err, overrun;
   int checks = 0, errors = 0, cyc = 0, fe_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   uart_rx_byte #(.CLKS_PER_BIT(CPB), .BYTE_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .rx(rx), .unload_uart(unload_uart),
      .dout(dout), .byte_rdy(byte_rdy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

   task automatic send_byte(input logic [7:0] d, input logic sb);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = sb;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_rdy(input int lim);
      int n = 0;
      while (byte_rdy !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_byte(input string name);
      checks++;
      if (byte_rdy !== 1'b1) begin
         errors++;
         $display("FAIL %s_rdy got %b want 1", name, byte_rdy);
      end
      exp_b = exp_q.pop_front();
      checks++;
      if (dout !== exp_b) begin
         errors++;
         $display("FAIL %s_dout got %h want %h", name, dout, exp_b);
      end
   endtask

   task automatic ack(input string name);
      unload_uart = 1'b1;
      @(negedge clk);
      unload_uart = 1'b0;
      checks++;
      if (byte_rdy !== 1'b0) begin
         errors++;
         $display("FAIL %s_ack got rdy=%b want 0", name, byte_rdy);
      end
   endtask

   task automatic test_reset;
      int bad = 0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({dout, byte_rdy, frame_err, overrun} !== 11'b0) begin
         errors++;
         $display("FAIL reset_async got dout=%h rdy=%b fe=%b ovr=%b want all 0",
                  dout, byte_rdy, frame_err, overrun);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (100 * CPB) begin
         @(negedge clk);
         if (byte_rdy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_quiet got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_single;
      int c0, lat;
      @(negedge clk);
      c0 = cyc;
      exp_q.push_back(8'hA5);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            wait_rdy(300);
            lat = cyc - c0;
         end
      join
      checks++;
      if (lat != 155) begin
         errors++;
         $display("FAIL single_latency got %0d want 155", lat);
      end
      check_byte("single");
      checks++;
      if (fe_cnt != 0) begin
         errors++;
         $display("FAIL single_fe got %0d want 0", fe_cnt);
      end
      ack("single");
   endtask

   task automatic test_glitch;
      int fe0 = fe_cnt;
      rx = 1'b0;
      repeat (6) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++;
      if (byte_rdy !== 1'b0 || fe_cnt != fe0) begin
         errors++;
         $display("FAIL glitch got rdy=%b fe=%0d want 0 0", byte_rdy, fe_cnt - fe0);
      end
      exp_q.push_back(8'h5C);
      send_byte(8'h5C, 1'b1);
      wait_rdy(50);
      check_byte("after_glitch");
      ack("after_glitch");
   endtask

   task automatic test_frame;
      int fe0 = fe_cnt;
      send_byte(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if (fe_cnt - fe0 != 1) begin
         errors++;
         $display("FAIL frame_pulses got %0d want 1", fe_cnt - fe0);
      end
      checks++;
      if (byte_rdy !== 1'b0) begin
         errors++;
         $display("FAIL frame_discard got rdy=%b want 0", byte_rdy);
      end
      exp_q.push_back(8'h81);
      send_byte(8'h81, 1'b1);
      wait_rdy(50);
      check_byte("after_frame");
      ack("after_frame");
   endtask

   task automatic test_overrun;
      int c1;
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      check_byte("overrun");
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_flag got %b want 1", overrun);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({dout, byte_rdy, overrun} !== 10'b0) begin
         errors++;
         $display("FAIL reset_busy got dout=%h rdy=%b ovr=%b want all 0", dout, byte_rdy, overrun);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      exp_q.push_back(8'h33);
      send_byte(8'h33, 1'b1);
      check_byte("first_of_pair");
      c1 = cyc;
      exp_q.push_back(8'h44);
      fork
         send_byte(8'h44, 1'b1);
         begin
            while (cyc < c1 + 154) @(negedge clk);
            unload_uart = 1'b1;
            @(negedge clk);
            unload_uart = 1'b0;
         end
      join
      check_byte("simul_ack");
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL simul_overrun got %b want 0", overrun);
      end
      ack("simul_ack");
   endtask

   task automatic test_reset_mid;
      logic [7:0] d = 8'h5A;
      int bad = 0;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = d[4];
      repeat (CPB / 2) @(negedge clk);
      #2 rst = 1'b1;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12 * CPB) begin
         @(negedge clk);
         if (byte_rdy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet got %0d active cycles want 0", bad);
      end
      exp_q.push_back(8'h0F);
      send_byte(8'h0F, 1'b1);
      wait_rdy(50);
      check_byte("after_reset_mid");
      ack("after_reset_mid");
   endtask

   initial begin
      test_reset;
      test_single;
      test_glitch;
      test_frame;
      test_overrun;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receive front end for the kicker/feedback control UART link. It oversamples the asynchronous `rx` line and deframes 8N1 characters. Each received byte is held in a one-entry buffer, with `byte_rdy` high until the downstream unload stage acknowledges it with `unload_uart`. It sits directly upstream of the UART unload/two-byte word decoder and drives that stage's `byte_rdy` and `din`.

## Interface
- `CLKS_PER_BIT`, 347, clock cycles per serial bit (40 MHz / 115200); legal range ≥ 4.
- `BYTE_WIDTH`, 8, data bits per character.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high; all state and outputs clear immediately.
- `rx` in 1: asynchronous serial line, idle high.
- `unload_uart` in 1: acknowledge from downstream; clears `byte_rdy`.
- `dout` out BYTE_WIDTH: last accepted byte, LSB received first.
- `byte_rdy` out 1: a byte in `dout` has not yet been acknowledged.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `overrun` out 1: sticky; a completed byte was dropped because the buffer was full.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized signal `rxs`.
- The bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. The bit index `bidx` is `$clog2(BYTE_WIDTH)` bits wide.
- States:
  - IDLE: on `rxs`=0, go to START and load `cnt`=0.
  - START: when `cnt`=`CLKS_PER_BIT/2`−1 (integer divide), sample `rxs`. If 0, go to DATA with `cnt`=0 and `bidx`=0. If 1, treat as a glitch and return to IDLE.
  - DATA: when `cnt`=`CLKS_PER_BIT`−1, shift `rxs` into the MSB of the shift register (right-shift, so the LSB arrives first) and reset `cnt`. After bit `BYTE_WIDTH`−1, go to STOP.
  - STOP: when `cnt`=`CLKS_PER_BIT`−1, sample `rxs`.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, and go to BRK.
  - BRK: wait for `rxs`=1, then go to IDLE. No start is detected while in BRK.
- Delivery at the stop-bit sample:
  - If `byte_rdy`=0, or `unload_uart`=1 in the same cycle: `dout`←shift register and `byte_rdy`←1.
  - Otherwise: `dout` and `byte_rdy` are unchanged and `overrun`←1.
- When `unload_uart`=1 and no delivery happens that cycle, `byte_rdy`←0. `unload_uart` while `byte_rdy`=0 is ignored.
- `overrun` clears only on `rst`.
- Reset values: `dout`=0, `byte_rdy`=0, `frame_err`=0, `overrun`=0, state IDLE, synchronizer and shift register at 1/0 respectively.
- Reset mid-character aborts it with no output activity afterwards. If `rx` is still low after reset, the core enters START and detects a start bit. A byte misaligned this way is accepted by design; downstream framing (the MSB tag) rejects it.

## Timing
- Start-edge to sample latency is 2 cycles (synchronizer) plus the state delays above. The stop-bit sample falls at roughly 9.5 bit times after the `rx` falling edge.
- `byte_rdy` rises and `dout` updates on the clock edge after the stop-bit sample cycle (registered). `frame_err` follows the same timing.
- The downstream stage returns `unload_uart` about 2 cycles after `byte_rdy` rises. `byte_rdy` falls on the edge after `unload_uart` is sampled.
- Back-to-back characters at full line rate (10 bit times each) never overrun while downstream acknowledges within `CLKS_PER_BIT`·9 cycles.
- `frame_err`, `byte_rdy` and `dout` are registered outputs with no combinational path from `rx`.

## Structure
- The shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BRK);
  - the default `CLKS_PER_BIT`;
  - `BYTE_WIDTH`.
  The same package is used by the unload/decoder stage.
- One natural sub-module, `sync_2ff`: a 1-bit synchronizer with a reset-value parameter, reused on other asynchronous inputs.

## Test plan
- Reset checks: assert `rst` asynchronously mid-clock -> all outputs 0 immediately. Drive `rx`=1 -> no activity for 100 bit times.
- Single byte: `CLKS_PER_BIT`=16, send 0xA5 -> `dout`=0xA5 and `byte_rdy`=1 one cycle after the stop sample; pulse `unload_uart` -> `byte_rdy`=0 the next cycle.
- Glitch: `rx` low for 6 cycles (< 8 = half bit) -> no `byte_rdy`, no `frame_err`, state returns to IDLE.
- Framing error: send 0x3C with stop bit 0, hold `rx` low 3 bit times, then send 0x81 -> one `frame_err` pulse, no delivery of 0x3C, `dout`=0x81 afterwards.
- Overrun and simultaneity: send 0x11 and 0x22 with no acknowledge -> `dout`=0x11, `overrun`=1. After reset, send 0x33 then 0x44 with `unload_uart` asserted exactly on 0x44's stop-sample cycle -> `dout`=0x44, `byte_rdy`=1, `overrun`=0.
- Reset mid-byte: assert `rst` during DATA bit 4 of 0x5A with `rx` high afterwards -> no delivery. The next 0x0F is received correctly.
